// File: rtl/mips16_ctrl_pkg.sv
// Shared encodings for the 16-bit multicycle MIPS control path:
// FSM states, opcodes, ALUOp codes and datapath mux selects.
package mips16_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_WB_R      = 4'd4,
    S_EXEC_SLTI = 4'd5,
    S_EXEC_ADDI = 4'd6,
    S_WB_I      = 4'd7,
    S_MEM_ADDR  = 4'd8,
    S_MEM_RD    = 4'd9,
    S_MEM_WB    = 4'd10,
    S_MEM_WR    = 4'd11,
    S_BRANCH    = 4'd12,
    S_JUMP      = 4'd13,
    S_JAL       = 4'd14
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_SLTI  = 3'b001;
  localparam logic [2:0] OP_J     = 3'b010;
  localparam logic [2:0] OP_JAL   = 3'b011;
  localparam logic [2:0] OP_LW    = 3'b100;
  localparam logic [2:0] OP_SW    = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_ADDI  = 3'b111;

  localparam logic [1:0] ALU_FUNCT = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_SLT   = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b11;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_R7 = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// 8-bit memory wait counter; flags a timeout on the cycle whose stall
// would bring the count to TIMEOUT. TIMEOUT = 0 never times out.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    timeout = enable && (LIMIT != '0) && (cnt_q == LIMIT - 8'd1);
    cnt_d   = cnt_q;
    if (clear || timeout) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the 16-bit multicycle MIPS datapath, with a
// watchdog on every memory-handshake state.
module multicycle_control
  import mips16_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       mem_err,
  output logic [3:0] state_dbg
);

  state_t state_q, state_d;
  logic   mem_err_q, mem_err_d;
  logic   wd_active, wd_clear, wd_en, wd_timeout;

  // Every exit from a memory state happens on mem_ready or timeout, so
  // clearing outside those states also gives the clear-on-entry behaviour.
  always_comb begin
    wd_active = is_mem_state(state_q);
    wd_clear  = !wd_active || mem_ready;
    wd_en     = wd_active && !mem_ready;
  end

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .timeout (wd_timeout)
  );

  always_comb begin
    mem_err_d = mem_err_q | wd_timeout;
    state_d   = S_IDLE;
    case (state_q)
      S_IDLE:      state_d = mem_err_q ? S_IDLE : S_FETCH;
      S_FETCH:     state_d = wd_timeout ? S_IDLE : (mem_ready ? S_DECODE : S_FETCH);
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_SLTI:      state_d = S_EXEC_SLTI;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_EXEC_ADDI;
        endcase
      end
      S_EXEC_R:    state_d = S_WB_R;
      S_EXEC_SLTI: state_d = S_WB_I;
      S_EXEC_ADDI: state_d = S_WB_I;
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    state_d = wd_timeout ? S_IDLE : (mem_ready ? S_MEM_WB : S_MEM_RD);
      S_MEM_WR:    state_d = wd_timeout ? S_IDLE : (mem_ready ? S_FETCH : S_MEM_WR);
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL: state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    alu_op        = '0;
    alu_src_a     = 1'b0;
    alu_src_b     = '0;
    reg_dst       = '0;
    mem_to_reg    = '0;
    reg_write     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = '0;
    instr_done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_TWO;
        alu_op    = ALU_ADD;
        pc_src    = PC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_SLTI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_SLT;
      end
      S_EXEC_ADDI, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_WB_R: begin
        reg_dst    = DST_RD;
        mem_to_reg = WB_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_I: begin
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_dst    = DST_RT;
        mem_to_reg = WB_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = DST_R7;
        mem_to_reg = WB_PC;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_err   = mem_err_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each cycle pushes the expected
// output word for the stimulus and compares it against the DUT at negedge.
module tb_multicycle_control;
  import mips16_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic       mem_ready;
  logic [1:0] alu_op, alu_src_b, reg_dst, mem_to_reg, pc_src;
  logic       alu_src_a, reg_write, i_or_d, mem_read, mem_write, ir_write;
  logic       pc_write, pc_write_cond, instr_done, mem_err;
  logic [3:0] state_dbg;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] v;
    string       tag;
  } exp_t;
  exp_t sb[$];

  multicycle_control #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .instr_done(instr_done), .mem_err(mem_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [23:0] obs;
  assign obs = {alu_op, alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write,
                i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
                pc_src, instr_done, mem_err, state_dbg};

  // Expected output word for a state, written from the state/output table.
  function automatic logic [23:0] golden(input state_t s, input logic r, input logic e);
    logic [1:0] aop, srcb, dst, m2r, psrc;
    logic srca, rw, iod, mr, mw, irw, pw, pwc, done;
    {aop, srcb, dst, m2r, psrc} = '0;
    {srca, rw, iod, mr, mw, irw, pw, pwc, done} = '0;
    case (s)
      S_FETCH:     begin mr = 1; srcb = 2'b01; aop = 2'b11; irw = r; pw = r; end
      S_DECODE:    begin srcb = 2'b11; aop = 2'b11; end
      S_EXEC_R:    begin srca = 1; end
      S_WB_R:      begin dst = 2'b01; rw = 1; done = 1; end
      S_EXEC_SLTI: begin srca = 1; srcb = 2'b10; aop = 2'b10; end
      S_EXEC_ADDI: begin srca = 1; srcb = 2'b10; aop = 2'b11; end
      S_WB_I:      begin rw = 1; done = 1; end
      S_MEM_ADDR:  begin srca = 1; srcb = 2'b10; aop = 2'b11; end
      S_MEM_RD:    begin mr = 1; iod = 1; end
      S_MEM_WB:    begin m2r = 2'b01; rw = 1; done = 1; end
      S_MEM_WR:    begin mw = 1; iod = 1; done = r; end
      S_BRANCH:    begin srca = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      S_JUMP:      begin pw = 1; psrc = 2'b10; done = 1; end
      S_JAL:       begin pw = 1; psrc = 2'b10; rw = 1; dst = 2'b10; m2r = 2'b10; done = 1; end
      default: ;
    endcase
    return {aop, srca, srcb, dst, m2r, rw, iod, mr, mw, irw, pw, pwc, psrc, done, e, 4'(s)};
  endfunction

  task automatic test_reset();
    exp_t t, e;
    reset = 1'b1; opcode = 3'b000; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    t.v = golden(S_IDLE, 1'b1, 1'b0); t.tag = "reset_hold"; sb.push_back(t);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    @(posedge clk); #1;
    reset = 1'b0;
    t.v = golden(S_IDLE, 1'b1, 1'b0); t.tag = "reset_release_idle"; sb.push_back(t);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    state_t     sts[4] = '{S_FETCH, S_DECODE, S_EXEC_R, S_WB_R};
    logic       rdy[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_t t, e;
    for (int c = 0; c < 4; c++) begin
      opcode = 3'b000; mem_ready = rdy[c];
      t.v = golden(sts[c], rdy[c], 1'b0); t.tag = "rtype"; sb.push_back(t);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s cycle %0d: got %h expected %h", e.tag, c, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    state_t sts[8] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_WB};
    logic   rdy[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t t, e;
    for (int c = 0; c < 8; c++) begin
      opcode = 3'b100; mem_ready = rdy[c];
      t.v = golden(sts[c], rdy[c], 1'b0); t.tag = "lw_stall"; sb.push_back(t);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s cycle %0d: got %h expected %h", e.tag, c, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jal();
    state_t     sts[6] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_JAL};
    logic [2:0] ops[6] = '{3'b110, 3'b110, 3'b110, 3'b011, 3'b011, 3'b011};
    exp_t t, e;
    for (int c = 0; c < 6; c++) begin
      opcode = ops[c]; mem_ready = 1'b1;
      t.v = golden(sts[c], 1'b1, 1'b0); t.tag = "branch_jal"; sb.push_back(t);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s cycle %0d: got %h expected %h", e.tag, c, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    state_t sts[16] = '{S_FETCH, S_DECODE, S_JUMP,
                        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_MEM_WR,
                        S_FETCH, S_DECODE, S_EXEC_SLTI, S_WB_I,
                        S_FETCH, S_DECODE, S_EXEC_ADDI, S_WB_I};
    logic [2:0] ops[16] = '{3'b010, 3'b010, 3'b010,
                            3'b101, 3'b101, 3'b101, 3'b101, 3'b101,
                            3'b001, 3'b001, 3'b001, 3'b001,
                            3'b111, 3'b111, 3'b111, 3'b111};
    exp_t t, e;
    logic r;
    for (int c = 0; c < 16; c++) begin
      r = (c != 6);
      opcode = ops[c]; mem_ready = r;
      t.v = golden(sts[c], r, 1'b0); t.tag = "back_to_back"; sb.push_back(t);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s cycle %0d: got %h expected %h", e.tag, c, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    state_t sts[7] = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_IDLE, S_IDLE, S_IDLE};
    logic   rdy[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic   err[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_t t, e;
    for (int c = 0; c < 7; c++) begin
      opcode = 3'b000; mem_ready = rdy[c];
      t.v = golden(sts[c], rdy[c], err[c]); t.tag = "timeout"; sb.push_back(t);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s cycle %0d: got %h expected %h", e.tag, c, obs, e.v); end
      @(posedge clk); #1;
    end
    reset = 1'b1; mem_ready = 1'b0;
    t.v = golden(S_IDLE, 1'b0, 1'b0); t.tag = "timeout_reset_clears"; sb.push_back(t);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    @(posedge clk); #1;
    reset = 1'b0;
    t.v = golden(S_IDLE, 1'b0, 1'b0); t.tag = "timeout_post_reset_idle"; sb.push_back(t);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout_edge();
    state_t sts[7] = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
    logic   rdy[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t t, e;
    for (int c = 0; c < 7; c++) begin
      opcode = 3'b110; mem_ready = rdy[c];
      t.v = golden(sts[c], rdy[c], 1'b0); t.tag = "timeout_edge"; sb.push_back(t);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin failures++; $display("FAIL %s cycle %0d: got %h expected %h", e.tag, c, obs, e.v); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch_jal();
    test_back_to_back();
    test_timeout();
    test_timeout_edge();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no completion expected finish before 100000");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style finite-state controller for the 16-bit multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp field into the ALU control unit, plus the mux, register-file, PC and memory enables.
- Memory accesses use a ready handshake with a watchdog timeout.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for mem_ready in any memory state. 0 disables the watchdog. The wait counter is 8 bits wide.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state IDLE
- opcode  in  3  instruction[15:13], valid from DECODE onward (IR already loaded)
- mem_ready  in  1  memory completes the current read/write this cycle
- alu_op  out  2  to ALU control: 00 R-type funct, 01 sub, 10 slt, 11 add
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = reg B, 01 = const 2, 10 = sign-ext imm, 11 = sign-ext imm<<1
- reg_dst  out  2  00 = rt, 01 = rd, 10 = r7
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- reg_write  out  1  register-file write enable
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- mem_err  out  1  sticky watchdog error; cleared only by reset
- state_dbg  out  4  current state encoding

Behaviour:
- Outputs are a pure decode of the state register. Any output not listed for a state is 0.
- During reset, state = IDLE and every output is 0, mem_err = 0 and the wait counter = 0.
- IDLE: all outputs 0. Goes to FETCH next cycle, unless mem_err = 1, in which case it stays in IDLE.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=11, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=11 (branch target into ALUOut).
  - Next state by opcode: 000 EXEC_R; 001 EXEC_SLTI; 010 JUMP; 011 JAL; 100/101 MEM_ADDR; 110 BRANCH; 111 EXEC_ADDI.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=00. Next: WB_R.
- WB_R: reg_dst=01, mem_to_reg=00, reg_write=1, instr_done=1. Next: FETCH.
- EXEC_SLTI: alu_src_a=1, alu_src_b=10, alu_op=10. Next: WB_I.
- EXEC_ADDI: alu_src_a=1, alu_src_b=10, alu_op=11. Next: WB_I.
- WB_I: reg_dst=00, mem_to_reg=00, reg_write=1, instr_done=1. Next: FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=11. Next: MEM_RD if opcode=100, MEM_WR if opcode=101.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_dst=00, mem_to_reg=01, reg_write=1, instr_done=1. Next: FETCH.
- MEM_WR: mem_write=1, i_or_d=1, instr_done=mem_ready. Waits for mem_ready, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1. Next: FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1. Next: FETCH.
- JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1. Next: FETCH.
  - The register file captures the already-incremented PC at the same edge that the PC loads the jump target.
- Latency with mem_ready held at 1:
  - R, slti, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, j, jal: 3 cycles.
- Watchdog (FETCH, MEM_RD, MEM_WR):
  - Counter clears on entry to the state and on mem_ready.
  - Increments each cycle that mem_ready=0.
  - If it reaches TIMEOUT (nonzero) with mem_ready still 0: set mem_err and go to IDLE. No writes are issued.
  - mem_ready=1 in the same cycle the counter hits TIMEOUT: the access completes, no error.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Reset asserted mid-instruction aborts it immediately; no partial writeback occurs after reset deasserts.
- Unused state encodings go to IDLE next cycle with all outputs 0.

Decomposition:
- Shared package mips16_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants (OP_RTYPE..OP_ADDI)
  - ALUOp constants
  - mux-select constants for alu_src_b, reg_dst, mem_to_reg, pc_src
- One sub-module, mem_watchdog: 8-bit wait counter with clear/enable/timeout outputs.
- The FSM and output decode stay in multicycle_control.

Test Plan:
- Reset → all outputs 0 and state_dbg=IDLE; after release, FETCH on the first edge with mem_read=1, alu_src_b=01, alu_op=11.
- opcode=000, mem_ready=1 → FETCH, DECODE, EXEC_R (alu_op=00), WB_R (reg_write=1, reg_dst=01); instr_done high in cycle 4 only.
- opcode=100, mem_ready low for 3 cycles in MEM_RD → held in MEM_RD 3 extra cycles, then MEM_WB with mem_to_reg=01; total 8 cycles.
- opcode=110 → BRANCH asserts pc_write_cond=1, pc_src=01, alu_op=01; back to FETCH after 3 cycles.
- opcode=011 → JAL cycle shows pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.
- TIMEOUT=4, mem_ready stuck 0 in FETCH → mem_err=1 after 4 wait cycles, state IDLE and held there; reset clears it. A repeat run with mem_ready=1 on the 4th cycle → no error.
